// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that shares one uart_tx serializer
// between NUM_REQ byte producers. It latches the granted byte onto uart_din,
// drives a clean uart_en pulse of EN_HOLD cycles, and then waits for tx_done
// or a timeout. A one-cycle GAP state keeps uart_en low between bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int EN_HOLD        = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_en,
    output logic [7:0]           uart_din,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic                 timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(EN_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        rr_q;
    logic [IW-1:0]        grant_q;
    logic [7:0]           din_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 en_q;
    logic                 busy_q;
    logic                 to_err_q;
    logic [HW-1:0]        hold_q;
    logic [TW-1:0]        to_q;

    logic                 sel_vld;
    logic [IW-1:0]        sel_idx;
    logic [7:0]           sel_byte;
    logic [IW-1:0]        rr_d;

    // Pick the first valid requester starting at rr_q; iterating from the
    // far end lets the closest offset overwrite the others.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_w;
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = 0;
        idx_w   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = IW'(idx);
            if (req_valid[idx_w]) begin
                sel_vld = 1'b1;
                sel_idx = idx_w;
            end
        end
    end

    // Byte of the selected requester and the pointer value after the current grantee.
    always_comb begin
        sel_byte = req_data[{sel_idx, 3'b000} +: 8];
        rr_d     = (grant_q == IDX_LAST) ? '0 : grant_q + IW'(1);
    end

    // Control FSM; every output comes straight from a register here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            din_q    <= '0;
            ready_q  <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            to_err_q <= 1'b0;
            hold_q   <= '0;
            to_q     <= '0;
        end else begin
            ready_q  <= '0;
            to_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_vld) begin
                        grant_q <= sel_idx;
                        din_q   <= sel_byte;
                        ready_q <= NUM_REQ'(1) << sel_idx;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                        to_q    <= '0;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // tx_done is ignored while the enable pulse is still being formed.
                    to_q <= to_q + TW'(1);
                    if (hold_q == HOLD_LAST) begin
                        en_q    <= 1'b0;
                        state_q <= S_WAIT_DONE;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    // A tx_done landing on the timeout cycle wins: no error.
                    if (tx_done) begin
                        rr_q    <= rr_d;
                        state_q <= S_GAP;
                    end else if (to_q == TO_LAST) begin
                        to_err_q <= 1'b1;
                        rr_q     <= rr_d;
                        state_q  <= S_GAP;
                    end else begin
                        to_q <= to_q + TW'(1);
                    end
                end
                S_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign uart_en     = en_q;
    assign uart_din    = din_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign timeout_err = to_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a per-cycle vector table for the simultaneous
// request case, plus hand sequences for fairness, timeout, the tx_done/timeout
// tie and reset in WAIT_DONE. tx_done is driven by the bench.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_en;
    logic [7:0]           uart_din;
    logic                 tx_done;
    logic                 busy;
    logic [1:0]           grant_id;
    logic                 timeout_err;

    int tests;
    int fails;
    int rdy_cnt [NUM_REQ];

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .EN_HOLD       (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .uart_en    (uart_en),
        .uart_din   (uart_din),
        .tx_done    (tx_done),
        .busy       (busy),
        .grant_id   (grant_id),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic       txd;
        logic [3:0] rdy;
        logic       en;
        logic       bsy;
        logic [1:0] gid;
        logic [7:0] din;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [7:0] byte_of(input int i);
        logic [31:0] d;
        d = {8'h33, 8'hA2, 8'h31, 8'h55};
        return d[8*i +: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) rdy_cnt[i]++;
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        tx_done   = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        tests     = 0;
        fails     = 0;
        req_data  = {8'h33, 8'hA2, 8'h31, 8'h55};
        req_valid = '0;
        tx_done   = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;

        //          vld      txd   rdy      en    bsy   gid   din
        tbl[0]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h31};
        tbl[1]  = '{4'b1000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h31};
        tbl[2]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h31};
        tbl[3]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h31};
        tbl[4]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h31};
        tbl[5]  = '{4'b1000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h31};
        tbl[6]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h31};
        tbl[7]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 8'h33};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 8'h33};
        tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 8'h33};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 8'h33};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h33};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h33};
        tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h33};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h33};
        tbl[15] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h55};

        // Reset values
        tick();
        tick();
        check("rst_uart_en",  32'(uart_en),     32'd0);
        check("rst_din",      32'(uart_din),    32'd0);
        check("rst_ready",    32'(req_ready),   32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_grant_id", 32'(grant_id),    32'd0);
        check("rst_timeout",  32'(timeout_err), 32'd0);
        rst = 1'b0;

        // Simultaneous requests 1 and 3, spurious tx_done in LAUNCH and IDLE
        for (int s = 0; s < 16; s++) begin
            req_valid = tbl[s].vld;
            tx_done   = tbl[s].txd;
            tick();
            check($sformatf("vec%0d_ready", s),   32'(req_ready),   32'(tbl[s].rdy));
            check($sformatf("vec%0d_en", s),      32'(uart_en),     32'(tbl[s].en));
            check($sformatf("vec%0d_busy", s),    32'(busy),        32'(tbl[s].bsy));
            check($sformatf("vec%0d_gid", s),     32'(grant_id),    32'(tbl[s].gid));
            check($sformatf("vec%0d_din", s),     32'(uart_din),    32'(tbl[s].din));
            check($sformatf("vec%0d_timeout", s), 32'(timeout_err), 32'd0);
        end
        tx_done = 1'b0;

        // Fairness: all four continuously valid for eight bytes
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
        req_valid = 4'hF;
        for (int b = 0; b < 8; b++) begin
            n = 0;
            while (req_ready == '0 && n < 20) begin
                tick();
                n++;
            end
            if (req_ready == '0) begin
                check("fair_grant_timeout", 32'(n), 32'd0);
                break;
            end
            check($sformatf("fair%0d_gid", b), 32'(grant_id), 32'(b % 4));
            check($sformatf("fair%0d_din", b), 32'(uart_din), 32'(byte_of(b % 4)));
            repeat (4) tick();
            check($sformatf("fair%0d_en_low", b), 32'(uart_en), 32'd0);
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        req_valid = '0;
        repeat (4) tick();
        for (int i = 0; i < NUM_REQ; i++) begin
            check($sformatf("fair_ready_count%0d", i), 32'(rdy_cnt[i]), 32'd2);
        end

        // Timeout: grant 0, no tx_done, then requester 2 two edges later
        do_reset();
        req_valid = 4'b0101;
        tick();
        check("to_first_ready", 32'(req_ready), 32'b0001);
        req_valid = 4'b0100;
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (timeout_err) break;
        end
        check("to_latency", 32'(n), 32'd100);
        check("to_busy_gap", 32'(busy), 32'd1);
        tick();
        check("to_pulse_len", 32'(timeout_err), 32'd0);
        check("to_no_early_grant", 32'(req_ready), 32'd0);
        tick();
        check("to_next_ready", 32'(req_ready), 32'b0100);
        check("to_next_gid", 32'(grant_id), 32'd2);
        check("to_next_din", 32'(uart_din), 32'hA2);

        // tx_done on the same cycle as the timeout limit: no error
        req_valid = '0;
        pulses = 0;
        repeat (99) begin
            tick();
            if (timeout_err) pulses++;
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (timeout_err) pulses++;
        check("tie_busy_gap", 32'(busy), 32'd1);
        tick();
        if (timeout_err) pulses++;
        check("tie_no_timeout", 32'(pulses), 32'd0);
        check("tie_idle", 32'(busy), 32'd0);

        // Reset in WAIT_DONE after rr_ptr has moved to 3
        do_reset();
        req_valid = 4'b0100;
        tick();
        check("rr_setup_gid", 32'(grant_id), 32'd2);
        req_valid = '0;
        repeat (5) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        req_valid = 4'b1000;
        tick();
        check("rr_setup_gid3", 32'(grant_id), 32'd3);
        req_valid = '0;
        repeat (5) tick();
        check("wd_busy", 32'(busy), 32'd1);
        check("wd_en", 32'(uart_en), 32'd0);
        rst = 1'b1;
        #1;
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_en",    32'(uart_en),   32'd0);
        check("arst_ready", 32'(req_ready), 32'd0);
        check("arst_gid",   32'(grant_id),  32'd0);
        check("arst_din",   32'(uart_din),  32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b1001;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'b0001);
        check("post_rst_gid",   32'(grant_id),  32'd0);
        check("post_rst_din",   32'(uart_din),  32'h55);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` serializer between `NUM_REQ` byte producers (core print port, perf-counter dump, debug monitor, …). It grants one requester at a time and latches its byte onto `uart_din`. It then produces the enable pulse `uart_tx` needs (edge-detected after a two-flop synchronizer) and holds the grant until the serializer's `tx_done` pulse, or until a timeout. It sits between the perf/debug sources and `uart_tx` in the `uart_axil` subsystem.

## Interface
- `NUM_REQ`, 4: number of requesters; ≥2.
- `EN_HOLD`, 4: cycles `uart_en` is held high per byte; ≥3 so the `uart_tx` synchronizer sees a clean rising edge.
- `TIMEOUT_CYCLES`, 65536: cycles from first `uart_en` high to forced release if no `tx_done`; must exceed one 10-bit frame (CLK_FREQ/UART_BPS·10).
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, NUM_REQ: per-requester byte pending; held until own `req_ready`.
- `req_data`, in, NUM_REQ·8: byte of requester i at [8i+7:8i]; stable while `req_valid[i]`.
- `req_ready`, out, NUM_REQ: one-cycle accept pulse, one-hot.
- `uart_en`, out, 1: to `uart_tx.uart_en`.
- `uart_din`, out, 8: to `uart_tx.uart_din`.
- `tx_done`, in, 1: from `uart_tx.tx_done`; one-cycle pulse.
- `busy`, out, 1: state ≠ IDLE.
- `grant_id`, out, max(1,$clog2(NUM_REQ)): index of current/last grantee.
- `timeout_err`, out, 1: one-cycle pulse on forced release.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, GAP. All outputs are registered.
- Round-robin pointer `rr_ptr` (reset 0). Search order: rr_ptr, rr_ptr+1, … mod NUM_REQ.
- IDLE: if any `req_valid`, pick the first valid index g in search order. On that edge: `grant_id`←g, `uart_din`←byte g, `req_ready[g]`←1, `uart_en`←1, hold/timeout counters←0, go to LAUNCH. Otherwise stay.
- LAUNCH: `req_ready` returns to 0 after its single cycle. `uart_en` stays 1 for exactly EN_HOLD cycles total, then drops to 0 and the state moves to WAIT_DONE. `tx_done` is ignored here.
- WAIT_DONE: `uart_en`=0. On `tx_done`, go to GAP and set `rr_ptr`←(g+1) mod NUM_REQ.
- Timeout: the counter runs from LAUNCH entry through WAIT_DONE. When count = TIMEOUT_CYCLES−1 with no `tx_done`, pulse `timeout_err`, advance `rr_ptr` as above, and go to GAP. If `tx_done` and the timeout land in the same cycle, `tx_done` wins and no error is raised.
- GAP: one cycle, then IDLE. This guarantees a low `uart_en` period between bytes.
- `uart_din` holds the granted byte from grant until the next grant. It never changes while `uart_tx` may sample it.
- `tx_done` in IDLE or GAP is ignored.
- `req_valid` is only sampled in IDLE. Dropping `req_valid` before `req_ready` is a protocol violation; the byte may still be sent.
- Counter width is $clog2(TIMEOUT_CYCLES+1). Wrap is impossible because release occurs first.

## Timing
- Reset values: `uart_en`=0, `uart_din`=0, `req_ready`=0, `busy`=0, `grant_id`=0, `timeout_err`=0, `rr_ptr`=0, state IDLE.
- Asserting `rst` mid-operation forces these values immediately. `uart_tx` must be reset by the same reset; a frame already in flight is not aborted by this block.
- Latency: `req_ready` and the rising edge of `uart_en` appear 1 cycle after `req_valid` is seen in IDLE.
- `uart_en` is high for EN_HOLD cycles, then low for ≥2 cycles (WAIT_DONE plus GAP) before it can rise again.
- Back-to-back: from the `tx_done` cycle, WAIT_DONE→GAP takes 1 edge and GAP→IDLE takes 1 edge. The next grant occurs 3 edges after `tx_done`.
- `busy` rises with the grant and falls on the GAP→IDLE edge.

## Test plan
- Single byte: `req_valid[0]`, `req_data`=0x55, real `uart_tx` instance (CLK_FREQ=5e7, BPS=1e6) → one `req_ready[0]` pulse; `uart_en` high 4 cycles; TX line shows start bit, bits 1,0,1,0,1,0,1,0, stop bit; `busy` low 2 cycles after `tx_done`.
- Simultaneous: req 1 (0x31) and req 3 (0x33) valid from reset → grants in order 1, then 3. Serial output is 0x31 then 0x33. No `timeout_err`.
- Fairness: all 4 requesters continuously valid for 8 bytes → `grant_id` sequence 0,1,2,3,0,1,2,3. Each `req_ready` pulses exactly twice.
- Timeout: TIMEOUT_CYCLES=100, `tx_done` tied 0 → `timeout_err` pulses 100 cycles after the grant edge. `rr_ptr` advances and the next valid requester is granted 2 edges later.
- Spurious/edge cases: `tx_done` pulses in IDLE and in LAUNCH → no state change. `tx_done` in the same cycle as the timeout limit → no `timeout_err`.
- Reset mid-WAIT_DONE: assert `rst` → `uart_en`, `busy`, `req_ready` are 0 without a clock edge. After release, the first grant goes to the lowest valid index (`rr_ptr`=0).
